// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Sized for the largest supported requester count (8).
package mem_arb_pkg;

  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One slot of the in-flight pipeline: the access is live and who issued it.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } inflight_t;

  // Round-robin pick. Priority runs last+1, last+2, ..., last (mod n).
  // Returns 1 when any request is asserted, and the winner index in idx.
  // The loop is bounded by MAX_REQ so that it unrolls to fixed hardware.
  function automatic logic rr_pick(input  logic [MAX_REQ-1:0]  req,
                                   input  logic [MAX_ID_W-1:0] last,
                                   input  int                  n,
                                   output int                  idx);
    logic found;
    int   k;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      k = (int'(last) + i) % n;
      if ((i <= n) && !found && req[k[MAX_ID_W-1:0]]) begin
        found = 1'b1;
        idx   = k;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin arbiter core: combinational pick plus the 'last granted' pointer.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           gnt,
  output logic                       found,
  output logic [id_width(N_REQ)-1:0] winner
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0] last;
  int              pick_idx;

  // Pick the highest-priority request relative to the last winner.
  always_comb begin
    pick_idx = 0;
    found    = rr_pick(MAX_REQ'(req), MAX_ID_W'(last), N_REQ, pick_idx);
    winner   = ID_W'(pick_idx);
    gnt      = '0;
    if (found) gnt[winner] = 1'b1;
  end

  // Remember the winner; reset so that requester 0 is first in line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= ID_W'(N_REQ - 1);
    end else if (found) begin
      last <= winner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares memory port B between N_REQ requesters. One grant per cycle, no
// back-pressure; completions come back LATENCY cycles after the grant,
// steered to the requester that issued the access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int LATENCY = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0]           we_i,
  input  logic [N_REQ-1:0][AW-1:0]   addr_i,
  input  logic [N_REQ-1:0][DW-1:0]   wdata_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           rvalid_o,
  output logic [DW-1:0]              rdata_o,
  output logic [AW-1:0]              mem_addr_o,
  output logic [DW-1:0]              mem_wdata_o,
  output logic                       mem_en_o,
  output logic                       mem_we_o,
  input  logic [DW-1:0]              mem_rdata_i
);

  localparam int ID_W = id_width(N_REQ);

  logic            grant;
  logic [ID_W-1:0] winner;
  inflight_t       pipe [LATENCY];
  inflight_t       tail;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_i),
    .gnt     (gnt_o),
    .found   (grant),
    .winner  (winner)
  );

  // Drive the memory port with the winner's command; quiet when idle.
  always_comb begin
    mem_en_o    = grant;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grant) begin
      mem_we_o    = we_i[winner];
      mem_addr_o  = addr_i[winner];
      mem_wdata_o = wdata_i[winner];
    end
  end

  // In-flight shift register: head takes this cycle's grant, tail retires.
  // Idle slots carry id 0 rather than X so the pipe stays deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0].valid <= grant;
      pipe[0].id    <= grant ? MAX_ID_W'(winner) : '0;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Retire the tail entry: one-hot completion to its issuer, data passthrough.
  always_comb begin
    tail     = pipe[LATENCY-1];
    rvalid_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rvalid_o[k] = tail.valid && (tail.id == MAX_ID_W'(k));
    end
    rdata_o = mem_rdata_i;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (LATENCY 1 and 3) share the same
// requester stimulus and are compared against a round-robin reference model.
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n;
  logic [N-1:0]         req, we;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;

  logic [N-1:0]  gnt1, gnt3, rv1, rv3;
  logic [DW-1:0] rd1, rd3, mwd1, mwd3, mrd1, mrd3;
  logic [AW-1:0] ma1, ma3;
  logic          me1, me3, mw1, mw3;

  mem_port_arbiter #(.N_REQ(N), .LATENCY(1), .AW(AW), .DW(DW)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1),
    .mem_addr_o(ma1), .mem_wdata_o(mwd1), .mem_en_o(me1), .mem_we_o(mw1),
    .mem_rdata_i(mrd1));

  mem_port_arbiter #(.N_REQ(N), .LATENCY(3), .AW(AW), .DW(DW)) u_dut_l3 (
    .clk(clk), .reset_n(reset_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3),
    .mem_addr_o(ma3), .mem_wdata_o(mwd3), .mem_en_o(me3), .mem_we_o(mw3),
    .mem_rdata_i(mrd3));

  int checks   = 0;
  int failures = 0;

  // Reference model: last winner and the grant history (-1 = no grant),
  // hist[0] is the grant of the previous cycle, hist[2] three cycles back.
  int last_m;
  int hist [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_model();
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last_m + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic clear_model();
    last_m = N - 1;
    for (int i = 0; i < 4; i++) hist[i] = -1;
  endtask

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] v;
    v = '0;
    if (id >= 0) v[id] = 1'b1;
    return v;
  endfunction

  // Check one cycle at the falling edge, then advance the model at the rising edge.
  task automatic step(output int w);
    logic          g;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    @(negedge clk);
    w = pick_model();
    g = (w >= 0);
    exp_we    = g ? we[w]    : 1'b0;
    exp_addr  = g ? addr[w]  : '0;
    exp_wdata = g ? wdata[w] : '0;
    chk("gnt_l1",   64'(gnt1), 64'(onehot(w)));
    chk("gnt_l3",   64'(gnt3), 64'(onehot(w)));
    chk("en_l1",    64'(me1),  64'(g));
    chk("en_l3",    64'(me3),  64'(g));
    chk("we_l1",    64'(mw1),  64'(exp_we));
    chk("addr_l1",  64'(ma1),  64'(exp_addr));
    chk("addr_l3",  64'(ma3),  64'(exp_addr));
    chk("wdata_l1", 64'(mwd1), 64'(exp_wdata));
    chk("rvalid_l1", 64'(rv1), 64'(onehot(hist[0])));
    chk("rvalid_l3", 64'(rv3), 64'(onehot(hist[2])));
    if (hist[0] >= 0) chk("rdata_l1", 64'(rd1), 64'(mrd1));
    if (hist[2] >= 0) chk("rdata_l3", 64'(rd3), 64'(mrd3));
    @(posedge clk);
    if (reset_n) begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = w;
      if (w >= 0) last_m = w;
    end
    #1;
  endtask

  int w;

  initial begin
    reset_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    mrd1 = '0; mrd3 = '0;
    clear_model();

    // Held in reset with two requesters pending: no completions.
    req = 3'b011;
    repeat (3) step(w);
    reset_n = 1'b1;
    step(w);                          // first grant after release goes to r0
    chk("first_winner", 64'(w), 64'd0);
    req = '0;
    step(w);

    // Single read from r0 at 0x100, memory answers 0xDEADBEEF.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h100;
    step(w);
    req = '0;
    mrd1 = 32'hDEADBEEF;
    step(w);
    repeat (3) step(w);

    // Two-way contention for 6 cycles, then all three for 9 cycles.
    req = 3'b011; addr[1] = 32'h200;
    repeat (6) step(w);
    req = 3'b111; addr[2] = 32'h300;
    repeat (9) step(w);
    req = '0;
    repeat (3) step(w);

    // Write from r1 to the exit address.
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h600d600c; wdata[1] = 32'h55;
    step(w);
    req = '0;
    repeat (3) step(w);

    // Back-to-back reads from r0; each completion carries a distinct word.
    req[0] = 1'b1; we[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr[0] = 32'h400 + 32'(i * 4);
      mrd1 = 32'hA000 + 32'(i);
      mrd3 = 32'hB000 + 32'(i);
      step(w);
    end
    req = '0;
    for (int i = 0; i < 4; i++) begin
      mrd3 = 32'hC000 + 32'(i);
      step(w);
    end

    // Reset one cycle after a grant: the access must never complete.
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h500;
    step(w);
    req = '0;
    reset_n = 1'b0;
    clear_model();
    step(w);
    reset_n = 1'b1;
    repeat (4) step(w);
    req = 3'b111;
    step(w);
    chk("winner_after_reset", 64'(w), 64'd0);
    req = '0;
    step(w);

    // Randomized traffic obeying the hold-until-granted protocol.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] && ($urandom_range(0, 1) == 1)) begin
          req[k]   = 1'b1;
          we[k]    = 1'($urandom_range(0, 1));
          addr[k]  = $urandom;
          wdata[k] = $urandom;
        end
      end
      mrd1 = $urandom;
      mrd3 = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        clear_model();
        step(w);
        reset_n = 1'b1;
      end else begin
        step(w);
        if (w >= 0) req[w] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the data port (port B) of the main memory between several requesters, such as the core's data interface and a program loader or debug master. Each cycle it grants at most one request, drives the memory port with the winner's command, and tracks in-flight accesses through a fixed-latency pipeline. Read data and completion are returned to the requester that issued the access. It sits between the requesters and `memory` inside `psp`.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `LATENCY`, 1, memory read latency in cycles, from command issue to `mem_rdata_i` valid (1..4)
- `AW`, 32, address width
- `DW`, 32, data width

- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_i`  in  N_REQ  per-requester request
- `we_i`  in  N_REQ  per-requester write (1) / read (0)
- `addr_i`  in  N_REQ×AW  per-requester address
- `wdata_i`  in  N_REQ×DW  per-requester write data
- `gnt_o`  out  N_REQ  one-hot grant, combinational, same cycle as memory issue
- `rvalid_o`  out  N_REQ  one-hot completion, LATENCY cycles after grant
- `rdata_o`  out  DW  read data, shared by all requesters, qualified by `rvalid_o`
- `mem_addr_o`  out  AW  to memory `addr_b`
- `mem_wdata_o`  out  DW  to memory `data_i_b`
- `mem_en_o`  out  1  to memory `data_en_b`
- `mem_we_o`  out  1  to memory `write_en_b`
- `mem_rdata_i`  in  DW  from memory `data_o_b`

## Operation
- Requester protocol: raise `req_i[k]` with `we_i/addr_i/wdata_i` stable. Hold all of them unchanged until the cycle `gnt_o[k]`=1. The handshake completes in that cycle. The requester may present a new request in the next cycle.
- Arbitration: a pointer `last` records the most recently granted index. Priority order is `last+1, last+2, … , last` (mod N_REQ). The highest-priority asserted `req_i` wins.
- `last` updates to the winner on any cycle with a grant and holds otherwise. Reset value is `N_REQ-1`, so requester 0 has first priority.
- When a grant is made, `mem_en_o`=1, `mem_we_o`=winner `we_i`, and `mem_addr_o`/`mem_wdata_o` take the winner's values.
- When no grant is made, all memory outputs are 0.
- Pipelining: one grant per cycle and no back-pressure. Up to LATENCY accesses can be in flight.
- In-flight tracking uses a LATENCY-deep shift register of {valid, id}. Each cycle a grant pushes {1, winner} and a non-grant pushes {0, x}.
- At the tail entry with valid=1, `rvalid_o[id]`=1 and `rdata_o`=`mem_rdata_i`.
- Writes also produce `rvalid_o` at the tail. `rdata_o` is don't-care for writes.
- `rdata_o` passes `mem_rdata_i` through combinationally. It is only meaningful when some `rvalid_o` bit is set.
- Address decode (e.g. the 0x600d600c exit write) is out of scope. The arbiter forwards all addresses untouched.

## Timing
- Grant latency: 0 cycles, since `gnt_o` is combinational from `req_i` and `last`. `gnt_o` is never asserted without the matching `req_i`.
- Completion latency: exactly LATENCY cycles after the grant cycle. With LATENCY=1, a grant in cycle t gives `rvalid_o` in cycle t+1.
- Back-to-back: grants in consecutive cycles give `rvalid_o` in consecutive cycles, in grant order.
- Simultaneous grant and completion in the same cycle is legal and independent.
- Fairness: with all N_REQ requesters asserting continuously, each is granted exactly once every N_REQ cycles.
- A lone requester is granted every cycle.
- Reset values: `last`=N_REQ-1; all shift-register valid bits 0; `rvalid_o`=0. With `req_i`=0, `gnt_o`=0 and all `mem_*_o`=0.
- Reset mid-operation: `reset_n` assertion clears in-flight entries immediately (asynchronous). No `rvalid_o` is ever produced for accesses granted before reset.

## Structure
- Package `mem_arb_pkg`: `localparam ID_W = $clog2(N_REQ)` helper function and typedef `inflight_t` {logic valid; logic [ID_W-1:0] id}. Also a function `rr_pick(req, last)` returning the winner index and a found flag.
- Sub-module `rr_arbiter`: the combinational round-robin pick plus the `last` register. The top level holds the muxing and the in-flight shift register.

## Test plan
- Reset: hold `reset_n`=0 with `req_i`=2'b11 -> `rvalid_o`=0. Release -> the first grant goes to requester 0.
- Single read: LATENCY=1, r0 reads 0x100, memory returns 0xDEADBEEF -> `gnt_o`=01 in cycle t, `mem_en_o`=1, `mem_we_o`=0, `mem_addr_o`=0x100. In t+1, `rvalid_o`=01 and `rdata_o`=0xDEADBEEF.
- Contention: r0 and r1 request continuously for 6 cycles -> grants 01,10,01,10,01,10 and `rvalid_o` follows the same sequence one cycle later.
- Write ack: r1 writes 0x55 to 0x600d600c -> `mem_we_o`=1, `mem_wdata_o`=0x55, `gnt_o`=10. `rvalid_o`=10 after LATENCY cycles.
- LATENCY=3 back-to-back: r0 issues reads at t, t+1, t+2 -> `rvalid_o[0]` at t+3, t+4, t+5 with data in order.
- Reset mid-flight: LATENCY=3, grant at t, `reset_n` low at t+1 -> no `rvalid_o` through t+5. `last` is restored to N_REQ-1.
